// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port between the VGA scan-out (master) and the frame memory (slave).
interface vga_frame_reader_if;
  logic [18:0] mem_raddr;
  logic [2:0]  mem_rdata;

  modport master (output mem_raddr, input mem_rdata);
  modport slave  (input mem_raddr, output mem_rdata);
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out of a 3-bit frame buffer with a 2-clock pixel pipeline.
// Optional 8-entry colour palette enabled by defining VGA_PALETTE_EN.
module vga_frame_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic               clock,
  input  logic               resetn,
  vga_frame_reader_if.master mem,
`ifdef VGA_PALETTE_EN
  input  logic               pal_we,
  input  logic [2:0]         pal_idx,
  input  logic [23:0]        pal_data,
`endif
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               in_vblank,
  output logic               vblank_start
);

  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_END  = 10'(H_VIS);
  localparam logic [9:0] V_END  = 10'(V_VIS);
  localparam logic [9:0] HS_ON  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_ON  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_VIS + V_FP + V_SYNC - 1);

  function automatic logic [23:0] expand_rgb(input logic [2:0] c);
    expand_rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  logic [9:0]  h_r, v_r, h_nxt_s, v_nxt_s;
  logic [18:0] addr_r, addr_nxt_s, raddr_r, raddr_nxt_s;
  logic        h_wrap_s, vis_s, vis_nxt_s, hs_s, vs_s;
  logic        vis1_r, hs1_r, vs1_r;
  logic [23:0] colour_s;

  // Stage 0 next-state: raster counters, address counter and the address issued with the next position
  always_comb begin
    h_nxt_s     = h_r;
    v_nxt_s     = v_r;
    addr_nxt_s  = addr_r;
    raddr_nxt_s = raddr_r;
    h_wrap_s    = (h_r == H_LAST);
    vis_s       = (h_r < H_END) && (v_r < V_END);
    hs_s        = !((h_r >= HS_ON) && (h_r <= HS_OFF));
    vs_s        = !((v_r >= VS_ON) && (v_r <= VS_OFF));
    if (h_wrap_s) begin
      h_nxt_s = 10'd0;
      if (v_r == V_LAST) begin
        v_nxt_s = 10'd0;
      end else begin
        v_nxt_s = v_r + 10'd1;
      end
    end else begin
      h_nxt_s = h_r + 10'd1;
    end
    // addr_r always equals mem_raddr while visible, so it restarts at 0 on the frame's last clock
    if (h_wrap_s && (v_r == V_LAST)) begin
      addr_nxt_s = 19'd0;
    end else if (vis_s) begin
      addr_nxt_s = addr_r + 19'd1;
    end else begin
      addr_nxt_s = addr_r;
    end
    vis_nxt_s = (h_nxt_s < H_END) && (v_nxt_s < V_END);
    if (vis_nxt_s) begin
      raddr_nxt_s = addr_nxt_s;
    end else begin
      raddr_nxt_s = raddr_r;
    end
  end

  // Stage 0 and stage 1 registers: counters, read address, delayed sync/visible flags, vblank status
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h_r          <= 10'd0;
      v_r          <= 10'd0;
      addr_r       <= 19'd0;
      raddr_r      <= 19'd0;
      vis1_r       <= 1'b0;
      hs1_r        <= 1'b1;
      vs1_r        <= 1'b1;
      in_vblank    <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      h_r          <= h_nxt_s;
      v_r          <= v_nxt_s;
      addr_r       <= addr_nxt_s;
      raddr_r      <= raddr_nxt_s;
      vis1_r       <= vis_s;
      hs1_r        <= hs_s;
      vs1_r        <= vs_s;
      in_vblank    <= (v_r >= V_END);
      vblank_start <= (h_r == 10'd0) && (v_r == V_END);
    end
  end

  assign mem.mem_raddr = raddr_r;

`ifdef VGA_PALETTE_EN
  logic [23:0] pal_r [0:7];

  // Palette registers, reloaded with the fixed bit-expansion colours on reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        pal_r[i] <= expand_rgb(3'(i));
      end
    end else if (pal_we) begin
      pal_r[pal_idx] <= pal_data;
    end
  end

  assign colour_s = pal_r[mem.mem_rdata];
`else
  assign colour_s = expand_rgb(mem.mem_rdata);
`endif

  // Stage 2 registered VGA pins; colour is forced black outside the visible region
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_hs               <= 1'b1;
      vga_vs               <= 1'b1;
      vga_blank_n          <= 1'b0;
      {vga_r, vga_g, vga_b} <= 24'd0;
    end else begin
      vga_hs               <= hs1_r;
      vga_vs               <= vs1_r;
      vga_blank_n          <= vis1_r;
      {vga_r, vga_g, vga_b} <= vis1_r ? colour_s : 24'd0;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a full-size instance for line-level timing and a reduced-timing
// instance for whole-frame behaviour, both compared every clock against a position-based model.
`timescale 1ns/1ps
module tb_vga_frame_reader;

  // reduced raster: 32 clocks per line, 17 lines per frame, 544 clocks per frame
  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #20 clock = ~clock;

  vga_frame_reader_if mem_f ();
  vga_frame_reader_if mem_s ();

  logic [2:0] ram_f [0:307199];
  logic [2:0] ram_s [0:159];
  logic [23:0] pal_model [0:7];

  logic       hs_f, vs_f, bn_f, ivb_f, vbs_f, hs_s, vs_s, bn_s, ivb_s, vbs_s;
  logic [7:0] r_f, g_f, b_f, r_s, g_s, b_s;

`ifdef VGA_PALETTE_EN
  logic        pal_we   = 1'b0;
  logic [2:0]  pal_idx  = 3'd0;
  logic [23:0] pal_data = 24'd0;
`endif

  vga_frame_reader u_full (
    .clock(clock), .resetn(resetn), .mem(mem_f),
`ifdef VGA_PALETTE_EN
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
`endif
    .vga_hs(hs_f), .vga_vs(vs_f), .vga_blank_n(bn_f),
    .vga_r(r_f), .vga_g(g_f), .vga_b(b_f),
    .in_vblank(ivb_f), .vblank_start(vbs_f)
  );

  vga_frame_reader #(
    .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_small (
    .clock(clock), .resetn(resetn), .mem(mem_s),
`ifdef VGA_PALETTE_EN
    .pal_we(1'b0), .pal_idx(3'd0), .pal_data(24'd0),
`endif
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bn_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .in_vblank(ivb_s), .vblank_start(vbs_s)
  );

  // synchronous-read frame memories: data valid one clock after the address
  always @(posedge clock) begin
    mem_f.mem_rdata <= ram_f[mem_f.mem_raddr];
    mem_s.mem_rdata <= ram_s[mem_s.mem_raddr[7:0]];
  end

  int n_pass = 0, n_total = 0;
  int t = 0;
  bit phase1 = 1'b0;
  int f_hs_low = 0, f_hs_first = -1, f_bn_cnt = 0;
  int f_addr_639 = -1, f_addr_799 = -1, f_addr_800 = -1;
  logic [23:0] f_rgb_t2 = 24'hx, f_rgb_t3 = 24'hx, f_rgb_t4 = 24'hx;
  logic f_bn_t2 = 1'bx;
  int s_vs_low = 0, s_vbs_cnt = 0, s_last_vbs = 0, s_max_addr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] colour_of(input logic [2:0] c);
    logic [23:0] rgb;
    rgb[23:16] = c[2] ? 8'hFF : 8'h00;
    rgb[15:8]  = c[1] ? 8'hFF : 8'h00;
    rgb[7:0]   = c[0] ? 8'hFF : 8'h00;
    return rgb;
  endfunction

  // address on the bus at raster position p (clocks since frame start, any frame)
  function automatic int exp_addr(input int p, input int hv, input int ht, input int vv, input int vt);
    int pf, h, v;
    pf = p % (ht * vt);
    h  = pf % ht;
    v  = pf / ht;
    if (v >= vv) return vv * hv - 1;
    if (h >= hv) return v * hv + hv - 1;
    return v * hv + h;
  endfunction

  task automatic check_inst(input string pfx, input int hv, input int hf, input int hs, input int hb,
                            input int vv, input int vf, input int vs, input int vb, input logic [23:0] col,
                            input logic [18:0] a_addr, input logic a_hs, input logic a_vs, input logic a_bn,
                            input logic [23:0] a_rgb, input logic a_ivb, input logic a_vbs);
    int ht, vt, p, h, v;
    bit vis;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    check({pfx, "raddr"}, a_addr, exp_addr(t, hv, ht, vv, vt));
    if (t >= 2) begin
      p = (t - 2) % (ht * vt);
      h = p % ht;
      v = p / ht;
      vis = (h < hv) && (v < vv);
      check({pfx, "hs"}, a_hs, !((h >= hv + hf) && (h < hv + hf + hs)));
      check({pfx, "vs"}, a_vs, !((v >= vv + vf) && (v < vv + vf + vs)));
      check({pfx, "blank_n"}, a_bn, vis);
      check({pfx, "rgb"}, a_rgb, vis ? col : 24'd0);
    end else begin
      check({pfx, "hs_pipe"}, {a_hs, a_vs, a_bn, a_rgb}, {3'b110, 24'd0});
    end
    p = (t - 1) % (ht * vt);
    check({pfx, "in_vblank"}, a_ivb, (p / ht) >= vv);
    check({pfx, "vblank_start"}, a_vbs, (p % ht == 0) && (p / ht == vv));
  endtask

  task automatic check_rst_all(input string pfx);
    check({pfx, "_f_raddr"}, mem_f.mem_raddr, 19'd0);
    check({pfx, "_f_pins"}, {hs_f, vs_f, bn_f, r_f, g_f, b_f, ivb_f, vbs_f}, {3'b110, 24'd0, 2'b00});
    check({pfx, "_s_raddr"}, mem_s.mem_raddr, 19'd0);
    check({pfx, "_s_pins"}, {hs_s, vs_s, bn_s, r_s, g_s, b_s, ivb_s, vbs_s}, {3'b110, 24'd0, 2'b00});
  endtask

  task automatic run(input int n);
    logic [23:0] col_f, col_s;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      t++;
      @(negedge clock);
      col_f = 24'd0;
      col_s = 24'd0;
      if (t >= 2) begin
        col_f = pal_model[ram_f[exp_addr(t - 2, 640, 800, 480, 525)]];
        col_s = colour_of(ram_s[exp_addr(t - 2, SHV, 32, SVV, 17)]);
      end
      check_inst("f_", 640, 16, 96, 48, 480, 10, 2, 33, col_f, mem_f.mem_raddr,
                 hs_f, vs_f, bn_f, {r_f, g_f, b_f}, ivb_f, vbs_f);
      check_inst("s_", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, col_s, mem_s.mem_raddr,
                 hs_s, vs_s, bn_s, {r_s, g_s, b_s}, ivb_s, vbs_s);
      if (vbs_s) begin
        if (s_last_vbs > 0) check("s_vblank_period", t - s_last_vbs, 544);
        s_last_vbs = t;
      end
      if (phase1) begin
        if (t >= 2 && t <= 801) begin
          if (!hs_f) begin
            f_hs_low++;
            if (f_hs_first < 0) f_hs_first = t;
          end
          if (bn_f) f_bn_cnt++;
        end
        if (t >= 2 && t <= 545 && !vs_s) s_vs_low++;
        if (vbs_s) s_vbs_cnt++;
        if (int'(mem_s.mem_raddr) > s_max_addr) s_max_addr = int'(mem_s.mem_raddr);
        if (t == 639) f_addr_639 = int'(mem_f.mem_raddr);
        if (t == 799) f_addr_799 = int'(mem_f.mem_raddr);
        if (t == 800) f_addr_800 = int'(mem_f.mem_raddr);
        if (t == 2) begin f_rgb_t2 = {r_f, g_f, b_f}; f_bn_t2 = bn_f; end
        if (t == 3) f_rgb_t3 = {r_f, g_f, b_f};
        if (t == 4) f_rgb_t4 = {r_f, g_f, b_f};
      end
`ifdef VGA_PALETTE_EN
      if (t == 1) begin
        pal_we = 1'b1; pal_idx = 3'd1; pal_data = 24'h123456;
      end
      if (t == 2) begin
        pal_we = 1'b0;
        pal_model[1] = 24'h123456;
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 307200; i++) ram_f[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 160; i++) ram_s[i] = 3'($urandom_range(0, 7));
    ram_f[0] = 3'b001;
    ram_f[1] = 3'b000;
    ram_f[2] = 3'b001;
    for (int i = 0; i < 8; i++) pal_model[i] = colour_of(3'(i));

    // reset held for 5 clocks
    resetn = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check_rst_all("reset");

    // release and scan: 3 full lines of the full instance, several frames of the small one
    resetn = 1'b1;
    t = 0;
    phase1 = 1'b1;
    run(2500);
    phase1 = 1'b0;

    check("f_addr_end_line0", f_addr_639, 639);
    check("f_addr_hold", f_addr_799, 639);
    check("f_addr_line1", f_addr_800, 640);
    check("f_hs_low_len", f_hs_low, 96);
    check("f_hs_first_low", f_hs_first, 658);
    check("f_blank_n_len", f_bn_cnt, 640);
    check("f_pixel0_blank_n", f_bn_t2, 1'b1);
    check("f_pixel0_rgb", f_rgb_t2, 24'h0000FF);
    check("f_pixel1_rgb", f_rgb_t3, 24'h000000);
`ifdef VGA_PALETTE_EN
    check("f_palette_rgb", f_rgb_t4, 24'h123456);
`else
    check("f_pixel2_rgb", f_rgb_t4, 24'h0000FF);
`endif
    check("s_vs_low_len", s_vs_low, 64);
    check("s_vblank_pulses", s_vbs_cnt, 5);
    check("s_last_addr", s_max_addr, SVV * SHV - 1);

    // asynchronous reset mid-line, between clock edges
    #5 resetn = 1'b0;
    #1 check_rst_all("async_reset");
    for (int i = 0; i < 8; i++) pal_model[i] = colour_of(3'(i));
    s_last_vbs = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_rst_all("reset_hold");
    resetn = 1'b1;
    t = 0;
    run(700);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
